// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, branch-taken
// flushes and a data-memory req/ack wait with timeout, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exmem_branch,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             exmem_zflag,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             pc_src,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN, MEMWAIT} state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               mem_err_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;

    logic       mem_acc;
    logic       take_br;
    logic       ld_use;
    logic       timeout;
    logic       mem_wait;
    logic [1:0] src_match;
    logic [4:0] src_reg [2];

    assign src_reg[0] = ifid_rs;
    assign src_reg[1] = ifid_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = (idex_rt == src_reg[gi]);
        end
    endgenerate

    assign mem_acc = exmem_memread | exmem_memwrite;
    assign take_br = exmem_branch & exmem_zflag;
    assign ld_use  = idex_memread & (idex_rt != 5'd0) & (|src_match);

    // An ack arriving on the last wait cycle counts as a normal completion, not a timeout.
    assign timeout  = (state_reg == MEMWAIT) && (wait_cnt_reg == WAIT_LAST) && !dmem_ack;
    assign mem_wait = ((state_reg == RUN) && mem_acc && !dmem_ack) ||
                      ((state_reg == MEMWAIT) && !dmem_ack && !timeout);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        case (state_reg)
            RUN: begin
                if (mem_acc && !dmem_ack)
                    state_next = MEMWAIT;
            end
            MEMWAIT: begin
                if (dmem_ack || timeout)
                    state_next = RUN;
                else
                    wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        dmem_req    = mem_acc & !rst;
        pc_en       = 1'b1;
        pc_src      = 1'b0;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_wait) begin
            // Whole front of the pipe freezes; MEM/WB gets bubbles until the access lands.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (take_br) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (ld_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (timeout)
                mem_err_reg <= 1'b1;
            if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch flush, memory wait,
// timeout and reset during a wait, with hand-computed control vectors.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        exmem_branch, exmem_memread, exmem_memwrite, exmem_zflag;
    logic        dmem_ack;
    logic        dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_flush, mem_err;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // {dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush}
    localparam logic [9:0] V_RST    = 10'b0_0_0_0_1_0_1_0_1_1;
    localparam logic [9:0] V_NORM   = 10'b0_1_0_1_0_1_0_1_0_0;
    localparam logic [9:0] V_NREQ   = 10'b1_1_0_1_0_1_0_1_0_0;
    localparam logic [9:0] V_LDUSE  = 10'b0_0_0_0_0_1_1_1_0_0;
    localparam logic [9:0] V_BR     = 10'b0_1_1_1_1_1_1_1_1_0;
    localparam logic [9:0] V_FREEZE = 10'b1_0_0_0_0_0_0_0_0_1;

    logic [9:0] ctrl;
    assign ctrl = {dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_flush};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_branch(exmem_branch), .exmem_memread(exmem_memread),
        .exmem_memwrite(exmem_memwrite), .exmem_zflag(exmem_zflag),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_en(pc_en), .pc_src(pc_src),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; combinational checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        exmem_branch = 0; exmem_memread = 0; exmem_memwrite = 0;
        exmem_zflag = 0; dmem_ack = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        settle();
        check("rst_ctrl", 32'(ctrl), 32'(V_RST));
        tick(); tick();
        rst = 1'b0;
        settle();
        check("post_rst_norm", 32'(ctrl), 32'(V_NORM));
        check("post_rst_cnt", 32'(stall_cnt), 32'd0);
        check("post_rst_err", 32'(mem_err), 32'd0);

        // 1. lw $2 ; add $3,$2,$4
        idex_memread = 1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd4;
        settle();
        check("lduse_rs", 32'(ctrl), 32'(V_LDUSE));
        tick();
        idex_memread = 0; idex_rt = 0;
        settle();
        check("lduse_after", 32'(ctrl), 32'(V_NORM));
        check("lduse_cnt", 32'(stall_cnt), 32'd1);

        // 2. rt = 0 never stalls; rt match via ifid_rt does
        idex_memread = 1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        settle();
        check("lduse_r0", 32'(ctrl), 32'(V_NORM));
        tick();
        check("lduse_r0_cnt", 32'(stall_cnt), 32'd1);
        idex_rt = 5'd5; ifid_rs = 5'd7; ifid_rt = 5'd5;
        settle();
        check("lduse_rt", 32'(ctrl), 32'(V_LDUSE));
        tick();
        check("lduse_rt_cnt", 32'(stall_cnt), 32'd2);

        // 3. taken branch overrides a simultaneous load-use
        exmem_branch = 1; exmem_zflag = 1;
        settle();
        check("br_over_lduse", 32'(ctrl), 32'(V_BR));
        tick();
        check("br_cnt", 32'(stall_cnt), 32'd2);
        clear_inputs();
        exmem_branch = 1; exmem_zflag = 0;
        settle();
        check("br_not_taken", 32'(ctrl), 32'(V_NORM));
        tick();

        // 4. sw with ack three cycles after the request
        clear_inputs();
        exmem_memwrite = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("sw_freeze%0d", i), 32'(ctrl), 32'(V_FREEZE));
            tick();
        end
        dmem_ack = 1;
        settle();
        check("sw_release", 32'(ctrl), 32'(V_NREQ));
        tick();
        check("sw_cnt", 32'(stall_cnt), 32'd5);

        // zero-wait access: ack with the request, no stall
        clear_inputs();
        exmem_memread = 1; dmem_ack = 1;
        settle();
        check("zero_wait", 32'(ctrl), 32'(V_NREQ));
        tick();
        check("zero_wait_cnt", 32'(stall_cnt), 32'd5);
        exmem_memread = 0;
        settle();
        check("stray_ack", 32'(ctrl), 32'(V_NORM));
        tick();
        check("stray_ack_cnt", 32'(stall_cnt), 32'd5);

        // 5. lw never acked: 16 frozen cycles then forced release
        clear_inputs();
        exmem_memread = 1;
        for (int i = 0; i < 16; i++) begin
            settle();
            check($sformatf("to_freeze%0d", i), 32'(ctrl), 32'(V_FREEZE));
            check($sformatf("to_err%0d", i), 32'(mem_err), 32'd0);
            tick();
        end
        settle();
        check("to_release", 32'(ctrl), 32'(V_NREQ));
        tick();
        check("to_err_set", 32'(mem_err), 32'd1);
        check("to_cnt", 32'(stall_cnt), 32'd21);
        clear_inputs();
        tick(); tick();
        check("to_err_sticky", 32'(mem_err), 32'd1);
        check("to_norm", 32'(ctrl), 32'(V_NORM));

        // 6. reset in the middle of a wait
        exmem_memwrite = 1;
        tick(); tick();
        settle();
        check("mw_freeze", 32'(ctrl), 32'(V_FREEZE));
        rst = 1;
        settle();
        check("mw_rst_ctrl", 32'(ctrl), 32'(V_RST));
        tick();
        check("mw_rst_cnt", 32'(stall_cnt), 32'd0);
        check("mw_rst_err", 32'(mem_err), 32'd0);
        check("mw_rst_req", 32'(dmem_req), 32'd0);
        rst = 0;
        exmem_memwrite = 0;
        settle();
        check("mw_rst_run", 32'(ctrl), 32'(V_NORM));
        tick();
        check("mw_rst_cnt2", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
